// File: rtl/hazard_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scheduler
// Description : Stall/forward controller for a 5-stage MIPS pipeline.
//               Tracks the destination register and remaining Tnew of the
//               instructions in E, M and W. Compares them with the D-stage
//               Tuse decode to produce the pipeline stall and all
//               forwarding-mux selects. Also times the mult/div busy window
//               and stalls HI/LO consumers until it ends.
// Ports       : clk          rising-edge clock
//               reset        asynchronous active-low reset
//               d_a1/d_a2    D-stage rs/rt indices
//               d_tuse_rs/rt cycles until D needs rs/rt (3 = unused)
//               d_wa/d_tnew  D-stage destination and cycles to result
//               d_md_use     D instruction touches the mult/div unit
//               e_md_start   E instruction starts mult/div this cycle
//               e_md_is_div  1 = div start, 0 = mult start
//               stall        hold F/D, bubble into E
//               fwd_*        forwarding-mux selects for D, E and M
//               md_busy      mult/div unit still computing
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_a1,
  input  logic [4:0] d_a2,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_wa,
  input  logic [1:0] d_tnew,
  input  logic       d_md_use,
  input  logic       e_md_start,
  input  logic       e_md_is_div,
  output logic       stall,
  output logic [1:0] fwd_rs_d,
  output logic [1:0] fwd_rt_d,
  output logic [1:0] fwd_rs_e,
  output logic [1:0] fwd_rt_e,
  output logic       fwd_rt_m,
  output logic       md_busy
);

  localparam int MD_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W  = $clog2(MD_MAX + 1);

  // In-flight scoreboard; tnew is relative to the stage holding the entry.
  logic [4:0]       e_wa, e_rs, e_rt;
  logic [1:0]       e_tnew;
  logic [4:0]       m_wa, m_rt;
  logic [1:0]       m_tnew;
  logic [4:0]       w_wa;
  logic [CNT_W-1:0] md_count;

  logic rs_stall, rt_stall, md_stall;

  // Register 0 is hard-wired, so it never matches a producer.
  function automatic logic hit(input logic [4:0] r, input logic [4:0] wa);
    return (r != 5'd0) && (wa == r);
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  function automatic logic op_stall(input logic [4:0] r, input logic [1:0] tuse,
                                    input logic [4:0] ew, input logic [1:0] et,
                                    input logic [4:0] mw, input logic [1:0] mt);
    return (tuse != 2'd3) &&
           ((hit(r, ew) && (et > tuse)) || (hit(r, mw) && (mt > tuse)));
  endfunction

  // A producer that matches but is not ready is skipped, so an older ready
  // stage may still supply the value; the stall covers the stale case.
  function automatic logic [1:0] d_sel(input logic [4:0] r,
                                       input logic [4:0] ew, input logic [1:0] et,
                                       input logic [4:0] mw, input logic [1:0] mt,
                                       input logic [4:0] ww);
    if (hit(r, ew) && (et == 2'd0))      return 2'd3;
    else if (hit(r, mw) && (mt == 2'd0)) return 2'd2;
    else if (hit(r, ww))                 return 2'd1;
    else                                 return 2'd0;
  endfunction

  function automatic logic [1:0] e_sel(input logic [4:0] r,
                                       input logic [4:0] mw, input logic [1:0] mt,
                                       input logic [4:0] ww);
    if (hit(r, mw) && (mt == 2'd0)) return 2'd2;
    else if (hit(r, ww))            return 2'd1;
    else                            return 2'd0;
  endfunction

  assign md_busy  = (md_count != '0);
  assign rs_stall = op_stall(d_a1, d_tuse_rs, e_wa, e_tnew, m_wa, m_tnew);
  assign rt_stall = op_stall(d_a2, d_tuse_rt, e_wa, e_tnew, m_wa, m_tnew);
  // A start in E this cycle is not yet reflected in the counter.
  assign md_stall = d_md_use && (md_busy || e_md_start);
  assign stall    = rs_stall | rt_stall | md_stall;

  assign fwd_rs_d = d_sel(d_a1, e_wa, e_tnew, m_wa, m_tnew, w_wa);
  assign fwd_rt_d = d_sel(d_a2, e_wa, e_tnew, m_wa, m_tnew, w_wa);
  assign fwd_rs_e = e_sel(e_rs, m_wa, m_tnew, w_wa);
  assign fwd_rt_e = e_sel(e_rt, m_wa, m_tnew, w_wa);
  assign fwd_rt_m = hit(m_rt, w_wa);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_wa     <= 5'd0;
      e_tnew   <= 2'd0;
      e_rs     <= 5'd0;
      e_rt     <= 5'd0;
      m_wa     <= 5'd0;
      m_tnew   <= 2'd0;
      m_rt     <= 5'd0;
      w_wa     <= 5'd0;
      md_count <= '0;
    end else begin
      if (stall) begin
        e_wa   <= 5'd0;
        e_tnew <= 2'd0;
        e_rs   <= 5'd0;
        e_rt   <= 5'd0;
      end else begin
        e_wa   <= d_wa;
        e_tnew <= sat_dec(d_tnew);
        e_rs   <= d_a1;
        e_rt   <= d_a2;
      end
      // M and W keep draining during a stall.
      m_wa   <= e_wa;
      m_tnew <= sat_dec(e_tnew);
      m_rt   <= e_rt;
      w_wa   <= m_wa;
      if (e_md_start && (md_count == '0))
        md_count <= e_md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      else if (md_count != '0)
        md_count <= md_count - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scheduler
// Description : Self-checking bench for hazard_scheduler. A reference model
//               records each instruction leaving D together with the absolute
//               cycle its result becomes available. Stage contents and ready
//               times follow from cycle arithmetic. Directed hazard scenarios
//               are followed by random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_a1, d_a2, d_wa;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_use, e_md_start, e_md_is_div;
  logic       stall, fwd_rt_m, md_busy;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

  hazard_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset),
    .d_a1(d_a1), .d_a2(d_a2), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_wa(d_wa), .d_tnew(d_tnew), .d_md_use(d_md_use),
    .e_md_start(e_md_start), .e_md_is_div(e_md_is_div),
    .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m),
    .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  // Reference model: hist[k] is the instruction that left D k cycles ago
  // (k=1 is in E, 2 in M, 3 in W); ready = absolute cycle of result.
  typedef struct {
    logic [4:0] wa;
    logic [4:0] rs;
    logic [4:0] rt;
    int         ready;
  } slot_t;

  slot_t hist[1:3];
  int    cyc;
  int    md_end;
  int    ncomp = 0;
  int    nfail = 0;

  logic       obs_stall, obs_busy;
  logic [1:0] obs_rs_d, obs_rt_d, obs_rs_e;

  function automatic int rem(int k);
    return (hist[k].ready > cyc) ? hist[k].ready - cyc : 0;
  endfunction

  function automatic logic mhit(logic [4:0] r, int k);
    return (r != 5'd0) && (hist[k].wa == r);
  endfunction

  function automatic logic m_opst(logic [4:0] r, logic [1:0] tu);
    if (tu == 2'd3) return 1'b0;
    for (int k = 1; k <= 2; k++)
      if (mhit(r, k) && rem(k) > int'(tu)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] m_dsel(logic [4:0] r);
    for (int k = 1; k <= 3; k++)
      if (mhit(r, k) && rem(k) == 0) return 2'(4 - k);
    return 2'd0;
  endfunction

  function automatic logic [1:0] m_esel(logic [4:0] r);
    for (int k = 2; k <= 3; k++)
      if (mhit(r, k) && rem(k) == 0) return 2'(4 - k);
    return 2'd0;
  endfunction

  task automatic model_clear();
    for (int k = 1; k <= 3; k++) hist[k] = '{5'd0, 5'd0, 5'd0, 0};
    md_end = 0;
    cyc    = 0;
  endtask

  task automatic check(string tag, logic [7:0] got, logic [7:0] exp);
    ncomp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One pipeline cycle: drive D/E inputs, check all outputs against the
  // model at the negedge, then advance the model across the posedge.
  task automatic step(logic [4:0] a1, logic [4:0] a2, logic [1:0] tr, logic [1:0] tt,
                      logic [4:0] wa, logic [1:0] tn, logic mdu, logic mds, logic isdiv);
    logic es, eb;
    d_a1 = a1; d_a2 = a2; d_tuse_rs = tr; d_tuse_rt = tt;
    d_wa = wa; d_tnew = tn; d_md_use = mdu; e_md_start = mds; e_md_is_div = isdiv;
    @(negedge clk);
    eb = (cyc < md_end);
    es = m_opst(a1, tr) | m_opst(a2, tt) | (mdu && (eb || mds));
    check("stall",    8'(stall),    8'(es));
    check("md_busy",  8'(md_busy),  8'(eb));
    check("fwd_rs_d", 8'(fwd_rs_d), 8'(m_dsel(a1)));
    check("fwd_rt_d", 8'(fwd_rt_d), 8'(m_dsel(a2)));
    check("fwd_rs_e", 8'(fwd_rs_e), 8'(m_esel(hist[1].rs)));
    check("fwd_rt_e", 8'(fwd_rt_e), 8'(m_esel(hist[1].rt)));
    check("fwd_rt_m", 8'(fwd_rt_m), 8'(mhit(hist[2].rt, 3)));
    obs_stall = stall; obs_busy = md_busy;
    obs_rs_d = fwd_rs_d; obs_rt_d = fwd_rt_d; obs_rs_e = fwd_rs_e;
    @(posedge clk);
    hist[3] = hist[2];
    hist[2] = hist[1];
    if (es) hist[1] = '{5'd0, 5'd0, 5'd0, 0};
    else    hist[1] = '{wa, a1, a2, cyc + int'(tn)};
    if (mds && !eb) md_end = cyc + 1 + (isdiv ? 10 : 5);
    cyc++;
    #1;
  endtask

  task automatic nop(int n);
    for (int i = 0; i < n; i++) step(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Assert reset between edges and check outputs clear asynchronously.
  task automatic mid_reset(string tag);
    #2 reset = 1'b0;
    model_clear();
    #1;
    check({tag, "_stall"}, 8'(stall), 8'd0);
    check({tag, "_busy"},  8'(md_busy), 8'd0);
    check({tag, "_fwd"},   8'({fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m}), 8'd0);
    d_a1 = 0; d_a2 = 0; d_tuse_rs = 3; d_tuse_rt = 3; d_wa = 0; d_tnew = 0;
    d_md_use = 0; e_md_start = 0; e_md_is_div = 0;
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
  endtask

  // Hold a mult/div consumer in D and count stall and busy cycles.
  task automatic md_window(string tag, logic isdiv, int exp_stall, int exp_busy);
    int ns, nb, guard;
    ns = 0; nb = 0; guard = 0;
    step(5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd2, 1'b1, 1'b1, isdiv);
    ns += int'(obs_stall); nb += int'(obs_busy);
    while (obs_stall && guard < 40) begin
      step(5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd2, 1'b1, 1'b0, 1'b0);
      ns += int'(obs_stall); nb += int'(obs_busy);
      guard++;
    end
    check({tag, "_stall_cycles"}, 8'(ns), 8'(exp_stall));
    check({tag, "_busy_cycles"},  8'(nb), 8'(exp_busy));
  endtask

  initial begin
    logic [4:0] a1, a2, wa;
    logic [1:0] tr, tt, tn;
    logic       mdu;
    reset = 1'b0;
    d_a1 = 0; d_a2 = 0; d_tuse_rs = 3; d_tuse_rt = 3; d_wa = 0; d_tnew = 0;
    d_md_use = 0; e_md_start = 0; e_md_is_div = 0;
    model_clear();
    #12;
    check("rst_stall", 8'(stall), 8'd0);
    check("rst_busy",  8'(md_busy), 8'd0);
    check("rst_fwd",   8'({fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m}), 8'd0);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    // lw $1 ; addu $2,$1,$3
    step(5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 2'd3, 1'b0, 1'b0, 1'b0);
    step(5'd1, 5'd3, 2'd1, 2'd1, 5'd2, 2'd2, 1'b0, 1'b0, 1'b0);
    check("lw_addu_stall1", 8'(obs_stall), 8'd1);
    step(5'd1, 5'd3, 2'd1, 2'd1, 5'd2, 2'd2, 1'b0, 1'b0, 1'b0);
    check("lw_addu_go", 8'(obs_stall), 8'd0);
    nop(1);
    check("lw_addu_fwd_e", 8'(obs_rs_e), 8'd1);
    nop(3);

    // addu $1 ; beq $1,$0
    step(5'd2, 5'd3, 2'd1, 2'd1, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0);
    step(5'd1, 5'd0, 2'd0, 2'd0, 5'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    check("alu_beq_stall", 8'(obs_stall), 8'd1);
    step(5'd1, 5'd0, 2'd0, 2'd0, 5'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    check("alu_beq_go", 8'(obs_stall), 8'd0);
    check("alu_beq_fwd_m", 8'(obs_rs_d), 8'd2);
    nop(3);

    // lw $1 ; beq $1 : two stalls, then W forward
    step(5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 2'd3, 1'b0, 1'b0, 1'b0);
    step(5'd1, 5'd0, 2'd0, 2'd0, 5'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    check("lw_beq_s1", 8'(obs_stall), 8'd1);
    step(5'd1, 5'd0, 2'd0, 2'd0, 5'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    check("lw_beq_s2", 8'(obs_stall), 8'd1);
    step(5'd1, 5'd0, 2'd0, 2'd0, 5'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    check("lw_beq_go", 8'(obs_stall), 8'd0);
    check("lw_beq_fwd_w", 8'(obs_rs_d), 8'd1);
    nop(3);

    // jal ; jr $31
    step(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0, 1'b0, 1'b0, 1'b0);
    step(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    check("jal_jr_stall", 8'(obs_stall), 8'd0);
    check("jal_jr_fwd_e", 8'(obs_rs_d), 8'd3);
    nop(3);

    // ori $0,$5 ; addu $2,$0,$0
    step(5'd5, 5'd0, 2'd1, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    step(5'd0, 5'd0, 2'd1, 2'd1, 5'd2, 2'd2, 1'b0, 1'b0, 1'b0);
    check("r0_stall", 8'(obs_stall), 8'd0);
    check("r0_fwd_d", 8'({obs_rs_d, obs_rt_d}), 8'd0);
    nop(3);

    md_window("div",  1'b1, 11, 10);
    nop(2);
    md_window("mult", 1'b0, 6, 5);
    nop(2);

    // Reset in the middle of a div window
    step(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd2, 1'b1, 1'b0, 1'b0);
    mid_reset("rst_div");
    step(5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd2, 1'b1, 1'b0, 1'b0);
    check("rst_div_after", 8'(obs_stall), 8'd0);
    nop(2);

    // Reset in the middle of a load-use stall
    step(5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 2'd3, 1'b0, 1'b0, 1'b0);
    step(5'd1, 5'd0, 2'd0, 2'd0, 5'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    check("rst_ld_pre", 8'(obs_stall), 8'd1);
    mid_reset("rst_ld");
    step(5'd1, 5'd0, 2'd0, 2'd0, 5'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    check("rst_ld_after", 8'(obs_stall), 8'd0);

    // Random traffic; a stalled D instruction is held until it issues.
    a1 = 0; a2 = 0; wa = 0; tr = 3; tt = 3; tn = 0; mdu = 0;
    for (int i = 0; i < 400; i++) begin
      if (!obs_stall) begin
        a1  = 5'($urandom_range(0, 3));
        a2  = 5'($urandom_range(0, 3));
        wa  = 5'($urandom_range(0, 3));
        tr  = 2'($urandom_range(0, 3));
        tt  = 2'($urandom_range(0, 3));
        tn  = 2'($urandom_range(0, 3));
        mdu = ($urandom_range(0, 99) < 15);
      end
      step(a1, a2, tr, tt, wa, tn, mdu, ($urandom_range(0, 99) < 10), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
`default_nettype wire
